// File: rtl/lif_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lif_pkg
//  Description : Shared constants and FSM encoding for the time-multiplexed
//                adaptive-threshold LIF scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package lif_pkg;

    // Membrane retention: s' = I + ((s * RETAIN_MUL) >> RETAIN_SHIFT)
    localparam int RETAIN_MUL   = 14;
    localparam int RETAIN_SHIFT = 4;

    // Threshold decay kicks in once the quiet-cycle counter exceeds DECAY_START;
    // the decrement grows by one for every 2**DECAY_SHIFT quiet steps.
    localparam int DECAY_START  = 5;
    localparam int DECAY_SHIFT  = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_DONE   = 2'd2
    } lif_state_e;

endpackage : lif_pkg
`default_nettype wire

// File: rtl/spike_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spike_fifo
//  Description : Small synchronous FIFO with full/empty flags. A push into a
//                full FIFO is accepted when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_cnt;

    logic             w_do_pop;
    logic             w_do_push;
    logic [PTR_W-1:0] w_wr_next;
    logic [PTR_W-1:0] w_rd_next;

    // Handshake qualification and pointer wrap
    always_comb begin
        w_do_pop  = i_pop && (r_cnt != '0);
        w_do_push = i_push && ((r_cnt != CNT_W'(DEPTH)) || w_do_pop);
        w_wr_next = (r_wr == PTR_W'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
        w_rd_next = (r_rd == PTR_W'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
    end

    // Storage, pointers and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= w_wr_next;
            end
            if (w_do_pop) begin
                r_rd <= w_rd_next;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd];
    assign o_full  = (r_cnt == CNT_W'(DEPTH));
    assign o_empty = (r_cnt == '0);

endmodule : spike_fifo
`default_nettype wire

// File: rtl/lif_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : lif_scheduler
//  Description : Sweeps one adaptive-threshold LIF datapath across
//                NUM_NEURONS virtual neurons per step pulse; spiking neuron
//                indices are queued in a FIFO drained over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int IDX_W       = 3,
    parameter int BASE_THR    = 50,
    parameter int ADAPT_INIT  = 250,
    parameter int ADAPT_CAP   = 170,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             cur_we,
    input  logic [IDX_W-1:0] cur_addr,
    input  logic [7:0]       cur_data,
    output logic             busy,
    output logic             done,
    output logic             spk_valid,
    output logic [IDX_W-1:0] spk_id,
    input  logic             spk_ready
);

    // Per-neuron register banks
    logic [7:0] r_mem_s [NUM_NEURONS];
    logic [7:0] r_mem_a [NUM_NEURONS];
    logic [7:0] r_mem_c [NUM_NEURONS];
    logic [7:0] r_mem_i [NUM_NEURONS];

    lif_state_e       r_fsm;
    lif_state_e       w_fsm_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;

    // Datapath signals for the neuron under update
    logic [7:0]  w_s;
    logic [7:0]  w_a;
    logic [7:0]  w_c;
    logic [7:0]  w_i;
    logic        w_spike;
    logic [11:0] w_prod;
    logic [7:0]  w_retained;
    logic [7:0]  w_s_next;
    logic [7:0]  w_c_next;
    logic [7:0]  w_a_next;
    logic [7:0]  w_dec;

    // Control signals
    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_pop;
    logic w_in_update;
    logic w_last;
    logic w_stall;
    logic w_wb;
    logic w_push;

    // Adaptive-threshold LIF update for the currently indexed neuron
    always_comb begin
        w_s        = r_mem_s[r_idx];
        w_a        = r_mem_a[r_idx];
        w_c        = r_mem_c[r_idx];
        w_i        = r_mem_i[r_idx];
        w_spike    = (w_s >= w_a);
        w_prod     = 12'(w_s) * 12'(RETAIN_MUL);
        w_retained = 8'(w_prod >> RETAIN_SHIFT);
        w_s_next   = w_i + w_retained;
        w_c_next   = w_spike ? 8'd0 : w_c + 8'd1;
        w_dec      = 8'd1 + (w_c >> DECAY_SHIFT);
        w_a_next   = w_a;
        if (w_spike && (w_a < 8'(ADAPT_CAP))) begin
            w_a_next = w_a + (w_i >> 2);
        end
        // Long silence decays the threshold toward the floor; this wins over
        // any spike-driven growth in the same step.
        if ((w_c > 8'(DECAY_START)) && (w_a > 8'(BASE_THR))) begin
            if ({1'b0, w_a} >= (9'(BASE_THR) + {1'b0, w_dec})) begin
                w_a_next = w_a - w_dec;
            end else begin
                w_a_next = 8'(BASE_THR);
            end
        end
    end

    // Writeback / FIFO push qualification, including the full-FIFO stall
    always_comb begin
        w_pop       = spk_valid && spk_ready;
        w_in_update = (r_fsm == S_UPDATE);
        w_last      = (r_idx == IDX_W'(NUM_NEURONS - 1));
        w_stall     = w_in_update && w_spike && w_fifo_full && !w_pop;
        w_wb        = w_in_update && !w_stall;
        w_push      = w_wb && w_spike;
    end

    // Next-state, index sequencing and status outputs
    always_comb begin
        w_fsm_next = r_fsm;
        w_idx_next = r_idx;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                if (step) begin
                    w_fsm_next = S_UPDATE;
                    w_idx_next = '0;
                end
            end
            S_UPDATE: begin
                busy = 1'b1;
                if (w_wb) begin
                    if (w_last) begin
                        w_fsm_next = S_DONE;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done       = 1'b1;
                w_fsm_next = S_IDLE;
            end
            default: begin
                w_fsm_next = S_IDLE;
            end
        endcase
    end

    // FSM state and sweep index registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm <= S_IDLE;
            r_idx <= '0;
        end else begin
            r_fsm <= w_fsm_next;
            r_idx <= w_idx_next;
        end
    end

    // Neuron banks: host current writes when idle, datapath writeback in sweep
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                r_mem_s[k] <= '0;
                r_mem_a[k] <= 8'(ADAPT_INIT);
                r_mem_c[k] <= '0;
                r_mem_i[k] <= '0;
            end
        end else begin
            if (cur_we && !w_in_update) begin
                r_mem_i[cur_addr] <= cur_data;
            end
            if (w_wb) begin
                r_mem_s[r_idx] <= w_s_next;
                r_mem_a[r_idx] <= w_a_next;
                r_mem_c[r_idx] <= w_c_next;
            end
        end
    end

    spike_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_spike_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (r_idx),
        .i_pop   (w_pop),
        .o_data  (spk_id),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign spk_valid = !w_fifo_empty;

endmodule : lif_scheduler
`default_nettype wire
